// File: rtl/branch_pkg.sv
// Shared constants and record layout for the branch resolve queue.
// The change encodings are the command values that the 2-bit-counter BHT expects.
package branch_pkg;
  localparam logic [1:0] CHANGE_IDLE = 2'b00;
  localparam logic [1:0] CHANGE_DEC  = 2'b10;
  localparam logic [1:0] CHANGE_INC  = 2'b11;

  localparam int PC_W_DEF  = 32;
  localparam int IDX_W_DEF = 6;
  localparam int DEPTH_DEF = 4;

  // One prediction as recorded at fetch, at the default PC width.
  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic                taken;
    logic [PC_W_DEF-1:0] target;
  } pred_rec_t;
endpackage

// File: rtl/pred_fifo.sv
// Generic synchronous FIFO with a first-word-fall-through head.
// It has an async active-low reset and a synchronous clear that empties the queue.
module pred_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    // Clear collapses the queue onto the post-pop read pointer and drops any push.
    if (clr) begin
      wr_ptr_d = rd_ptr_d;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/branch_resolve_queue.sv
// Holds fetch-time branch predictions until execute resolves them in order, drives
// the BHT update, and flags mispredicts with a redirect PC and a wrong-path flush.
module branch_resolve_queue
  import branch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int PC_W  = PC_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PC_W-1:0]         fetch_pc,
  input  logic                    pred_valid,
  input  logic [PC_W-1:0]         pred_pc,
  input  logic                    pred_taken,
  input  logic [PC_W-1:0]         pred_target,
  output logic                    pred_ready,
  input  logic                    res_valid,
  input  logic                    res_taken,
  input  logic [PC_W-1:0]         res_target,
  output logic [IDX_W-1:0]        predictor_index,
  output logic [1:0]              change,
  output logic                    mispredict,
  output logic [PC_W-1:0]         redirect_pc,
  output logic                    res_error,
  output logic [$clog2(DEPTH):0]  count
);
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } rec_t;

  rec_t             wr_rec, head;
  logic             full, empty, pop, mis;
  logic [1:0]       change_q, change_d;
  logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
  logic             mispredict_q, mispredict_d;
  logic [PC_W-1:0]  redirect_q, redirect_d;
  logic             res_error_q, res_error_d;
  logic             unused_fetch_bits;

  assign wr_rec = '{pc: pred_pc, taken: pred_taken, target: pred_target};

  pred_fifo #(.WIDTH($bits(rec_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clr   (pop && mis),
    .push  (pred_valid),
    .pop   (pop),
    .wdata (wr_rec),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    pop          = res_valid && !empty;
    mis          = (head.taken != res_taken) || (res_taken && (head.target != res_target));
    change_d     = CHANGE_IDLE;
    upd_idx_d    = upd_idx_q;
    mispredict_d = 1'b0;
    redirect_d   = redirect_q;
    res_error_d  = res_valid && empty;
    if (pop) begin
      change_d     = res_taken ? CHANGE_INC : CHANGE_DEC;
      upd_idx_d    = head.pc[IDX_W+1:2];
      mispredict_d = mis;
      redirect_d   = res_taken ? res_target : head.pc + PC_W'(4);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      change_q     <= CHANGE_IDLE;
      upd_idx_q    <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      res_error_q  <= 1'b0;
    end else begin
      change_q     <= change_d;
      upd_idx_q    <= upd_idx_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      res_error_q  <= res_error_d;
    end
  end

  // During an update cycle the BHT must see the resolved branch's index, not fetch's.
  assign predictor_index   = (change_q != CHANGE_IDLE) ? upd_idx_q : fetch_pc[IDX_W+1:2];
  assign pred_ready        = !full;
  assign change            = change_q;
  assign mispredict        = mispredict_q;
  assign redirect_pc       = redirect_q;
  assign res_error         = res_error_q;
  assign unused_fetch_bits = ^{fetch_pc[PC_W-1:IDX_W+2], fetch_pc[1:0]};
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios plus a randomized run, all
// checked against an in-order queue model of the predictions in flight.
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc, pred_pc, pred_target, res_target, redirect_pc;
  logic        pred_valid, pred_taken, pred_ready, res_valid, res_taken;
  logic        mispredict, res_error;
  logic [5:0]  predictor_index;
  logic [1:0]  change;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  // Model: queue of {pc, taken, target} plus the expected registered results.
  logic [64:0] exp_q[$];
  logic [1:0]  e_change;
  logic [5:0]  e_idx;
  logic        e_mis, e_err;
  logic [31:0] e_redirect;

  branch_resolve_queue #(.DEPTH(DEPTH), .IDX_W(6), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .predictor_index(predictor_index), .change(change), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .res_error(res_error), .count(count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    exp_q.delete();
    e_change = 2'b00; e_idx = '0; e_mis = 1'b0; e_err = 1'b0; e_redirect = '0;
  endtask

  // Apply the current inputs for one clock edge and advance the model alongside.
  task automatic tick();
    logic [64:0] e;
    logic        flush;
    int          sz;
    sz       = exp_q.size();
    flush    = 1'b0;
    e_err    = res_valid && (sz == 0);
    e_change = 2'b00;
    e_mis    = 1'b0;
    if (res_valid && sz != 0) begin
      e          = exp_q.pop_front();
      e_mis      = (e[32] != res_taken) || (res_taken && e[31:0] != res_target);
      e_change   = res_taken ? 2'b11 : 2'b10;
      e_idx      = e[40:35];
      e_redirect = res_taken ? res_target : e[64:33] + 32'd4;
      if (e_mis) begin
        exp_q.delete();
        flush = 1'b1;
      end
    end
    if (pred_valid && sz < DEPTH && !flush) exp_q.push_back({pred_pc, pred_taken, pred_target});
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
  endtask

  task automatic push_rec(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_target = tgt;
  endtask

  // Resolve the head with the outcome the model says was predicted (no mispredict).
  task automatic resolve_correct();
    res_valid  = 1'b1;
    res_taken  = exp_q[0][32];
    res_target = exp_q[0][31:0];
  endtask

  task automatic test_reset();
    checks++; if (count !== 3'd0 || change !== 2'b00 || mispredict !== 1'b0 || res_error !== 1'b0 || redirect_pc !== 32'd0) begin
      errors++; $display("FAIL reset_hold: count=%0d change=%b mis=%b err=%b redir=%h, need 0/00/0/0/0", count, change, mispredict, res_error, redirect_pc);
    end
    reset = 1'b1;
    push_rec(32'h100, 1'b0, 32'h0); tick();
    push_rec(32'h104, 1'b1, 32'h200); tick();
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL reset_prefill: count=%0d need 2", count); end
    resolve_correct();
    reset = 1'b0;
    @(posedge clk); #1;
    res_valid = 1'b0;
    model_reset();
    checks++; if (count !== 3'd0 || change !== 2'b00 || pred_ready !== 1'b1 || mispredict !== 1'b0) begin
      errors++; $display("FAIL reset_mid_queue: count=%0d change=%b ready=%b mis=%b, need 0/00/1/0", count, change, pred_ready, mispredict);
    end
    reset = 1'b1;
    tick();
    checks++; if (change !== 2'b00 || count !== 3'd0) begin
      errors++; $display("FAIL reset_no_update: change=%b count=%0d need 00/0", change, count);
    end
  endtask

  task automatic test_predict_hit();
    push_rec(32'h40, 1'b1, 32'h80); tick();
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h80; tick();
    checks++; if (change !== 2'b11 || predictor_index !== 6'd16 || mispredict !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL predict_hit: change=%b idx=%0d mis=%b count=%0d need 11/16/0/0", change, predictor_index, mispredict, count);
    end
    fetch_pc = 32'h20; tick();
    checks++; if (change !== 2'b00 || predictor_index !== 6'd8) begin
      errors++; $display("FAIL hit_then_idle: change=%b idx=%0d need 00/8", change, predictor_index);
    end
  endtask

  task automatic test_mispredict();
    push_rec(32'h44, 1'b1, 32'h300); tick();
    res_valid = 1'b1; res_taken = 1'b0; res_target = 32'h0; tick();
    checks++; if (change !== 2'b10 || mispredict !== 1'b1 || redirect_pc !== 32'h48 || predictor_index !== 6'd17) begin
      errors++; $display("FAIL mispredict: change=%b mis=%b redir=%h idx=%0d need 10/1/48/17", change, mispredict, redirect_pc, predictor_index);
    end
    tick();
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL mis_pulse: mis=%b need 0", mispredict); end
  endtask

  task automatic test_flush_with_push();
    push_rec(32'h500, 1'b0, 32'h0); tick();
    push_rec(32'h504, 1'b1, 32'h600); tick();
    push_rec(32'h508, 1'b0, 32'h0); tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_prefill: count=%0d need 3", count); end
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h700;
    push_rec(32'h50C, 1'b0, 32'h0); tick();
    checks++; if (count !== 3'd0 || mispredict !== 1'b1 || redirect_pc !== 32'h700 || change !== 2'b11) begin
      errors++; $display("FAIL flush_push: count=%0d mis=%b redir=%h change=%b need 0/1/700/11", count, mispredict, redirect_pc, change);
    end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < DEPTH; i++) begin
      push_rec(32'h1000 + 32'(i * 4), i[0], 32'h2000 + 32'(i * 16)); tick();
    end
    checks++; if (pred_ready !== 1'b0 || count !== 3'd4) begin
      errors++; $display("FAIL full: ready=%b count=%0d need 0/4", pred_ready, count);
    end
    resolve_correct(); push_rec(32'h1FF0, 1'b0, 32'h0); tick();
    checks++; if (count !== 3'd3 || change !== 2'b10 || predictor_index !== 6'd0 || mispredict !== 1'b0) begin
      errors++; $display("FAIL full_push_pop: count=%0d change=%b idx=%0d mis=%b need 3/10/0/0", count, change, predictor_index, mispredict);
    end
    for (int i = 0; i < 8; i++) begin
      resolve_correct();
      push_rec(32'h3000 + 32'(i * 4), 1'(i % 3 == 0), 32'h4000 + 32'(i * 8)); tick();
      checks++; if (count !== 3'(exp_q.size()) || predictor_index !== e_idx || change !== e_change || mispredict !== 1'b0) begin
        errors++; $display("FAIL wrap_%0d: count=%0d idx=%0d change=%b mis=%b need %0d/%0d/%b/0", i, count, predictor_index, change, mispredict, exp_q.size(), e_idx, e_change);
      end
    end
  endtask

  task automatic test_back_to_back();
    while (exp_q.size() != 0) begin
      resolve_correct(); tick();
      checks++; if (change === 2'b00 || change !== e_change || predictor_index !== e_idx) begin
        errors++; $display("FAIL back_to_back: change=%b idx=%0d need %b/%0d", change, predictor_index, e_change, e_idx);
      end
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drained: count=%0d need 0", count); end
  endtask

  task automatic test_empty_error();
    fetch_pc = 32'hFC; res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h40;
    push_rec(32'h900, 1'b0, 32'h0); tick();
    checks++; if (res_error !== 1'b1 || change !== 2'b00 || predictor_index !== 6'd63 || count !== 3'd1 || mispredict !== 1'b0) begin
      errors++; $display("FAIL empty_res: err=%b change=%b idx=%0d count=%0d mis=%b need 1/00/63/1/0", res_error, change, predictor_index, count, mispredict);
    end
    tick();
    checks++; if (res_error !== 1'b0) begin errors++; $display("FAIL err_pulse: err=%b need 0", res_error); end
  endtask

  task automatic test_random();
    logic [1:0] want_pidx_sel;
    for (int n = 0; n < 400; n++) begin
      fetch_pc = $urandom;
      if ($urandom_range(0, 99) < 55) push_rec({$urandom_range(0, 32'hFFFF), 2'b00}, 1'($urandom_range(0, 1)), {$urandom_range(0, 15), 2'b00});
      if ($urandom_range(0, 99) < 45) begin
        res_valid = 1'b1;
        if (exp_q.size() != 0 && $urandom_range(0, 99) < 70) resolve_correct();
        else begin res_taken = 1'($urandom_range(0, 1)); res_target = {$urandom_range(0, 15), 2'b00}; end
      end
      tick();
      want_pidx_sel = e_change;
      checks++; if (count !== 3'(exp_q.size()) || pred_ready !== (exp_q.size() != DEPTH)) begin
        errors++; $display("FAIL rnd_count_%0d: count=%0d ready=%b need %0d/%b", n, count, pred_ready, exp_q.size(), exp_q.size() != DEPTH);
      end
      checks++; if (change !== e_change || mispredict !== e_mis || res_error !== e_err) begin
        errors++; $display("FAIL rnd_result_%0d: change=%b mis=%b err=%b need %b/%b/%b", n, change, mispredict, res_error, e_change, e_mis, e_err);
      end
      checks++; if (predictor_index !== ((want_pidx_sel != 2'b00) ? e_idx : fetch_pc[7:2])) begin
        errors++; $display("FAIL rnd_index_%0d: idx=%0d need %0d", n, predictor_index, (want_pidx_sel != 2'b00) ? e_idx : fetch_pc[7:2]);
      end
      if (e_mis) begin
        checks++; if (redirect_pc !== e_redirect) begin
          errors++; $display("FAIL rnd_redirect_%0d: redir=%h need %h", n, redirect_pc, e_redirect);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; fetch_pc = '0; pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0;
    pred_target = '0; res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_predict_hit();
    test_mispredict();
    test_flush_with_push();
    test_full_wrap();
    test_back_to_back();
    test_empty_error();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
